// File: rtl/keccak_padder_if.sv
// keccak_padder_if
// Groups the message-side and block-side stream signals of the Keccak padder.
//   start, msg_byte_size   : begin a message and give its total byte length
//   in_data/in_valid/in_ready : message lanes from upstream (byte 0 in bits 7:0)
//   out_data/out_valid/out_ready : padded lanes towards the absorb datapath
//   out_last_word          : lane is the last lane of a rate block
//   out_last_msg           : lane is the final lane of the padded message
//   busy                   : padder is working on a message
// The master modport is the side that feeds messages and drains blocks;
// the slave modport is the padder itself.
interface keccak_padder_if #(
    parameter int W      = 64,
    parameter int SIZE_W = 32
) ();
    logic              start;
    logic [SIZE_W-1:0] msg_byte_size;
    logic [W-1:0]      in_data;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last_word;
    logic              out_last_msg;
    logic              busy;

    modport master (
        output start, msg_byte_size, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last_word, out_last_msg, busy
    );

    modport slave (
        input  start, msg_byte_size, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last_word, out_last_msg, busy
    );
endinterface

// File: rtl/keccak_padder.sv
// keccak_padder
// Turns a byte-length-tagged stream of W-bit message lanes into complete
// rate-sized blocks with SHA-3 domain separation and pad10*1 applied.
// Message lanes pass straight through combinationally; once the message runs
// out the padder generates the domain byte, zero lanes and the closing 0x80
// itself, including a whole extra block when the message ends on a block
// boundary.
// Ports:
//   clk  : clock
//   rst  : asynchronous reset, active low
//   bus  : keccak_padder_if slave modport (message in, padded lanes out)
module keccak_padder #(
    parameter int          W          = 64,
    parameter int          RATE_WORDS = 17,
    parameter int          SIZE_W     = 32,
    parameter logic [7:0]  DSBYTE     = 8'h06
) (
    input  logic            clk,
    input  logic            rst,
    keccak_padder_if.slave  bus
);

    localparam int BPW   = W / 8;
    localparam int IDX_W = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(RATE_WORDS - 1);
    localparam logic [SIZE_W-1:0] BPW_S    = SIZE_W'(BPW);

    typedef enum logic [1:0] {
        IDLE,
        ABSORB,
        PAD,
        ZERO_FILL
    } state_t;

    state_t            state, state_next;
    logic [SIZE_W-1:0] bytes_left, bytes_left_next;
    logic [IDX_W-1:0]  word_idx, word_idx_next;

    logic              last_lane;
    logic              out_valid_c;
    logic              out_fire;
    logic              last_msg_c;
    logic [W-1:0]      data_c;
    logic [W-1:0]      tail_lane;

    assign last_lane   = (word_idx == LAST_IDX);

    // In ABSORB the output handshake and the input handshake are the same
    // event, so out_valid mirrors in_valid and in_ready mirrors out_ready.
    assign out_valid_c = (state == ABSORB) ? bus.in_valid
                                           : ((state == PAD) || (state == ZERO_FILL));
    assign out_fire    = out_valid_c && bus.out_ready;

    assign bus.out_valid     = out_valid_c;
    assign bus.in_ready      = (state == ABSORB) && bus.out_ready;
    assign bus.out_last_word = last_lane && out_valid_c;
    assign bus.out_last_msg  = last_msg_c;
    assign bus.busy          = (state != IDLE);
    assign bus.out_data      = data_c;

    // Partial final message lane: keep the remaining message bytes, put the
    // domain byte right after them and clear the junk above. If this lane
    // also closes the block, the pad10*1 terminator lands in the top byte
    // (it merges with the domain byte when only one byte slot is left).
    always_comb begin
        tail_lane = '0;
        for (int b = 0; b < BPW; b++) begin
            if (SIZE_W'(b) < bytes_left) begin
                tail_lane[b*8 +: 8] = bus.in_data[b*8 +: 8];
            end else if (SIZE_W'(b) == bytes_left) begin
                tail_lane[b*8 +: 8] = DSBYTE;
            end
        end
        if (last_lane) begin
            tail_lane[W-1 -: 8] = tail_lane[W-1 -: 8] | 8'h80;
        end
    end

    // Next-state and output data. word_idx follows every output handshake
    // regardless of state; bytes_left only shrinks when a full lane leaves,
    // so it can never wrap below zero.
    always_comb begin
        state_next      = state;
        bytes_left_next = bytes_left;
        word_idx_next   = word_idx;
        data_c          = '0;
        last_msg_c      = 1'b0;

        if (out_fire) begin
            word_idx_next = last_lane ? '0 : (word_idx + IDX_W'(1));
        end

        case (state)
            IDLE: begin
                if (bus.start) begin
                    bytes_left_next = bus.msg_byte_size;
                    word_idx_next   = '0;
                    state_next      = (bus.msg_byte_size == '0) ? PAD : ABSORB;
                end
            end

            ABSORB: begin
                if (bytes_left >= BPW_S) begin
                    data_c = bus.in_data;
                end else begin
                    data_c     = tail_lane;
                    last_msg_c = last_lane && bus.in_valid;
                end
                if (out_fire) begin
                    if (bytes_left > BPW_S) begin
                        bytes_left_next = bytes_left - BPW_S;
                    end else if (bytes_left == BPW_S) begin
                        // Message ends exactly on a lane: padding starts on
                        // the next lane, possibly in a fresh block.
                        bytes_left_next = '0;
                        state_next      = PAD;
                    end else begin
                        bytes_left_next = '0;
                        state_next      = last_lane ? IDLE : ZERO_FILL;
                    end
                end
            end

            PAD: begin
                data_c[7:0] = DSBYTE;
                if (last_lane) begin
                    data_c[W-1 -: 8] = data_c[W-1 -: 8] | 8'h80;
                end
                last_msg_c = last_lane;
                if (out_fire) begin
                    state_next = last_lane ? IDLE : ZERO_FILL;
                end
            end

            ZERO_FILL: begin
                if (last_lane) begin
                    data_c[W-1 -: 8] = 8'h80;
                    last_msg_c       = 1'b1;
                end
                if (out_fire && last_lane) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State registers; reset drops any partial block on the floor.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bytes_left <= '0;
            word_idx   <= '0;
        end else begin
            state      <= state_next;
            bytes_left <= bytes_left_next;
            word_idx   <= word_idx_next;
        end
    end

endmodule

// File: tb/tb_keccak_padder.sv
// tb_keccak_padder
// Self-checking bench for keccak_padder (SHA3-256 configuration).
// A driver issues messages and pushes the expected padded lanes, computed
// from the plain SHA-3 padding rule on a byte array, into a scoreboard
// queue; a separate monitor pops and compares on every output handshake and
// checks that stalled outputs hold steady.
module tb_keccak_padder;

    localparam int W          = 64;
    localparam int RATE_WORDS = 17;
    localparam int SIZE_W     = 32;
    localparam int BPW        = W / 8;
    localparam int RATE_BYTES = RATE_WORDS * BPW;
    localparam int BUDGET     = 5000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    keccak_padder_if #(.W(W), .SIZE_W(SIZE_W)) bus ();

    keccak_padder #(
        .W          (W),
        .RATE_WORDS (RATE_WORDS),
        .SIZE_W     (SIZE_W),
        .DSBYTE     (8'h06)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         lw;
        logic         lm;
    } exp_t;

    exp_t       expQ[$];
    logic [7:0] msgBytes[$];
    int         errors    = 0;
    int         checks    = 0;
    int         hsCount   = 0;
    int         laneNum   = 0;
    bit         stallMode = 1'b0;

    task automatic checkValue(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkValue($sformatf("lane%0d_data", laneNum), bus.out_data, e.data);
        checkValue($sformatf("lane%0d_last_word", laneNum), W'(bus.out_last_word), W'(e.lw));
        checkValue($sformatf("lane%0d_last_msg", laneNum), W'(bus.out_last_msg), W'(e.lm));
        laneNum++;
    endtask

    // Reference: pad the byte string to a whole number of rate blocks with
    // 0x06 after the message and 0x80 in the very last byte, then cut it
    // into little-endian lanes.
    task automatic pushModel(input int size);
        int         total;
        int         nl;
        logic [7:0] pad[];
        exp_t       e;
        total = (size / RATE_BYTES + 1) * RATE_BYTES;
        pad = new[total];
        for (int i = 0; i < total; i++) pad[i] = 8'h00;
        for (int i = 0; i < size; i++) pad[i] = msgBytes[i];
        pad[size]    = pad[size] | 8'h06;
        pad[total-1] = pad[total-1] | 8'h80;
        nl = total / BPW;
        for (int j = 0; j < nl; j++) begin
            e.data = '0;
            for (int b = 0; b < BPW; b++) e.data[b*8 +: 8] = pad[j*BPW + b];
            e.lw = ((j % RATE_WORDS) == RATE_WORDS - 1);
            e.lm = (j == nl - 1);
            expQ.push_back(e);
        end
    endtask

    task automatic fillMsg(input int n);
        msgBytes.delete();
        for (int i = 0; i < n; i++) msgBytes.push_back(8'($urandom));
    endtask

    task automatic applyStimulus(input int size, input bit ffGarbage, input bit useModel, input int abortAt);
        int           nLanes;
        int           hsBase;
        int           i;
        int           guard;
        bit           acc;
        bit           aborted;
        int           idx;
        logic [W-1:0] lanes[$];
        logic [W-1:0] ln;

        nLanes = (size + BPW - 1) / BPW;
        for (int j = 0; j < nLanes; j++) begin
            ln = '0;
            for (int b = 0; b < BPW; b++) begin
                idx = j * BPW + b;
                ln[b*8 +: 8] = (idx < size) ? msgBytes[idx] : (ffGarbage ? 8'hFF : 8'($urandom));
            end
            lanes.push_back(ln);
        end
        if (useModel) pushModel(size);
        hsBase = hsCount;

        @(posedge clk); #1;
        bus.start         = 1'b1;
        bus.msg_byte_size = SIZE_W'(size);
        bus.in_valid      = 1'b0;
        @(posedge clk); #1;
        bus.start         = 1'b0;
        bus.msg_byte_size = $urandom;

        i       = 0;
        guard   = 0;
        aborted = 1'b0;
        while (i < nLanes && guard < BUDGET) begin
            if (abortAt > 0 && i == abortAt) begin
                aborted = 1'b1;
                break;
            end
            if (!bus.in_valid && (!stallMode || $urandom_range(0, 3) != 0)) begin
                bus.in_valid = 1'b1;
                bus.in_data  = lanes[i];
            end
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            guard++;
            if (acc) begin
                i++;
                bus.in_valid = 1'b0;
            end
        end

        if (aborted) begin
            rst          = 1'b0;
            bus.in_valid = 1'b0;
            expQ.delete();
            @(negedge clk);
            checkValue("reset_busy", W'(bus.busy), '0);
            checkValue("reset_out_valid", W'(bus.out_valid), '0);
            checkValue("reset_in_ready", W'(bus.in_ready), '0);
            checkValue("reset_last_word", W'(bus.out_last_word), '0);
            checkValue("reset_last_msg", W'(bus.out_last_msg), '0);
            @(posedge clk); #1;
            rst = 1'b1;
            return;
        end

        if (i < nLanes) begin
            checks++;
            errors++;
            $display("[TB] FAIL input_timeout: got %0d lanes accepted, expected %0d", i, nLanes);
        end

        // Stray valid while the padder generates padding must be ignored.
        bus.in_valid = 1'b1;
        bus.in_data  = {$urandom, $urandom};
        guard = 0;
        while (expQ.size() != 0 && guard < BUDGET) begin
            @(posedge clk); #1;
            guard++;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL output_timeout: got %0d lanes still pending, expected 0", expQ.size());
            expQ.delete();
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checkValue("busy_after_msg", W'(bus.busy), '0);
        checkValue("in_handshakes", W'(hsCount - hsBase), W'(nLanes));
    endtask

    task automatic readyLoop();
        forever begin
            @(posedge clk); #1;
            bus.out_ready = stallMode ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    endtask

    task automatic monitorLoop();
        logic [W-1:0] holdData;
        logic         holdLw;
        logic         holdLm;
        bit           holding;
        exp_t         e;
        holding  = 1'b0;
        holdData = '0;
        holdLw   = 1'b0;
        holdLm   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                holding = 1'b0;
            end else begin
                if (bus.in_valid && bus.in_ready) hsCount++;
                if (holding) begin
                    checkValue("stall_valid", W'(bus.out_valid), W'(1));
                    checkValue("stall_data", bus.out_data, holdData);
                    checkValue("stall_flags", W'({bus.out_last_word, bus.out_last_msg}), W'({holdLw, holdLm}));
                end
                holding = 1'b0;
                if (bus.out_valid && !bus.out_ready) begin
                    holding  = 1'b1;
                    holdData = bus.out_data;
                    holdLw   = bus.out_last_word;
                    holdLm   = bus.out_last_msg;
                end else if (bus.out_valid && bus.out_ready) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_lane: got %h, expected no lane", bus.out_data);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput(e);
                    end
                end
            end
        end
    endtask

    initial begin
        exp_t e;
        int   n;
        bus.start         = 1'b0;
        bus.msg_byte_size = '0;
        bus.in_data       = '0;
        bus.in_valid      = 1'b0;
        bus.out_ready     = 1'b1;

        fork
            readyLoop();
            monitorLoop();
        join_none

        repeat (2) @(negedge clk);
        checkValue("rst_out_valid", W'(bus.out_valid), '0);
        checkValue("rst_in_ready", W'(bus.in_ready), '0);
        checkValue("rst_busy", W'(bus.busy), '0);
        checkValue("rst_last_word", W'(bus.out_last_word), '0);
        checkValue("rst_last_msg", W'(bus.out_last_msg), '0);
        checkValue("rst_out_data", bus.out_data, '0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Empty message: one block of pure padding, written out literally.
        msgBytes.delete();
        for (int j = 0; j < RATE_WORDS; j++) begin
            e.data = (j == 0) ? 64'h0000_0000_0000_0006 :
                     (j == RATE_WORDS - 1) ? 64'h8000_0000_0000_0000 : 64'h0;
            e.lw   = (j == RATE_WORDS - 1);
            e.lm   = (j == RATE_WORDS - 1);
            expQ.push_back(e);
        end
        $display("[TB] zero-length message");
        applyStimulus(0, 1'b0, 1'b0, 0);

        $display("[TB] abc with 0xFF junk above the message");
        msgBytes.delete();
        msgBytes.push_back(8'h61);
        msgBytes.push_back(8'h62);
        msgBytes.push_back(8'h63);
        applyStimulus(3, 1'b1, 1'b1, 0);

        $display("[TB] lane and block boundary sizes");
        fillMsg(8);   applyStimulus(8,   1'b0, 1'b1, 0);
        fillMsg(135); applyStimulus(135, 1'b0, 1'b1, 0);
        fillMsg(136); applyStimulus(136, 1'b0, 1'b1, 0);

        $display("[TB] random stalls");
        stallMode = 1'b1;
        fillMsg(300); applyStimulus(300, 1'b0, 1'b1, 0);
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 420);
            fillMsg(n);
            applyStimulus(n, 1'b0, 1'b1, 0);
        end

        $display("[TB] reset in the middle of a message");
        fillMsg(300); applyStimulus(300, 1'b0, 1'b1, 20);
        msgBytes.delete();
        msgBytes.push_back(8'h61);
        msgBytes.push_back(8'h62);
        msgBytes.push_back(8'h63);
        applyStimulus(3, 1'b1, 1'b1, 0);
        fillMsg(136); applyStimulus(136, 1'b0, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
